muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/reg_dec4to16.sv | 13 +
 rtl/muldiv_ctrl.sv | 155 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the MUL/DIV microcode controller: opcodes, IR fields, states.
// Build option: define MULDIV_CTRL_DIV_EN to make the DIV opcode legal.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6
    } state_e;

    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;

    function automatic logic is_legal_op(input logic [4:0] op);
`ifdef MULDIV_CTRL_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/reg_dec4to16.sv
// 4-to-16 one-hot decoder with enable, drives the register-file output enables.
module reg_dec4to16 (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] dec
);

    always_comb begin
        dec = '0;
        if (en) dec[sel] = 1'b1;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Hardwired control unit: fetch, decode and execute MUL (and optionally DIV) over T0..T6.
// Build option: MULDIV_CTRL_DIV_EN enables the DIV opcode (see muldiv_pkg::is_legal_op).
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        Clear,
    input  logic        start,
    input  logic [31:0] IR,
    input  logic        mem_rdy,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhiout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic [15:0] Rout,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_e     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic [3:0] ra_q, ra_d;
    logic [3:0] rb_q, rb_d;

    logic       dec_en;
    logic [3:0] dec_sel;

    logic [4:0] ir_op;
    logic [3:0] ir_ra;
    logic [3:0] ir_rb;

    assign ir_op = IR[OP_MSB:OP_LSB];
    assign ir_ra = IR[RA_MSB:RA_LSB];
    assign ir_rb = IR[RB_MSB:RB_LSB];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
        end
    end

    // NOTE: every output and next-state gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        dec_en  = 1'b0;
        dec_sel = '0;
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Zhiout  = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        LOin    = 1'b0;
        HIin    = 1'b0;
        alu_op  = '0;
        done    = 1'b0;
        illegal = 1'b0;

        unique case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_rdy) state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            // IR was loaded at the end of T2, so it is decoded straight from the port here.
            S_T3: begin
                if (is_legal_op(ir_op)) begin
                    op_d    = ir_op;
                    ra_d    = ir_ra;
                    rb_d    = ir_rb;
                    dec_en  = 1'b1;
                    dec_sel = ir_ra;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_T4: begin
                dec_en  = 1'b1;
                dec_sel = rb_q;
                alu_op  = op_q;
                Zin     = 1'b1;
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                LOin    = 1'b1;
                state_d = S_T6;
            end
            S_T6: begin
                Zhiout  = 1'b1;
                HIin    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    reg_dec4to16 u_rout_dec (
        .en  (dec_en),
        .sel (dec_sel),
        .dec (Rout)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a microcode-step reference model.
module tb_muldiv_ctrl;

`ifdef MULDIV_CTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [31:0] IR_MUL_R1_R2 = 32'h7090_0000;
    localparam logic [31:0] IR_DIV_R3_R4 = 32'h79A0_0000;

    logic        clk     = 1'b0;
    logic        Clear   = 1'b1;
    logic        start   = 1'b0;
    logic        mem_rdy = 1'b0;
    logic [31:0] IR      = '0;

    logic        PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read;
    logic        MDRin, MDRout, IRin, Yin, LOin, HIin;
    logic [15:0] Rout;
    logic [4:0]  alu_op;
    logic        busy, done, illegal;

    muldiv_ctrl dut (
        .clk     (clk),
        .Clear   (Clear),
        .start   (start),
        .IR      (IR),
        .mem_rdy (mem_rdy),
        .PCout   (PCout),
        .MARin   (MARin),
        .IncPC   (IncPC),
        .Zin     (Zin),
        .Zlowout (Zlowout),
        .Zhiout  (Zhiout),
        .PCin    (PCin),
        .Read    (Read),
        .MDRin   (MDRin),
        .MDRout  (MDRout),
        .IRin    (IRin),
        .Yin     (Yin),
        .LOin    (LOin),
        .HIin    (HIin),
        .Rout    (Rout),
        .alu_op  (alu_op),
        .busy    (busy),
        .done    (done),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // Bit map: 37 PCout .. 24 HIin, 23:8 Rout, 7:3 alu_op, 2 busy, 1 done, 0 illegal.
    logic [37:0] dut_vec;
    assign dut_vec = {PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read,
                      MDRin, MDRout, IRin, Yin, LOin, HIin, Rout, alu_op,
                      busy, done, illegal};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: position in the instruction's microcode sequence
    // (0 = idle, 1..7 = T0..T6) plus the fields captured at decode.
    int         m_step = 0;
    logic [4:0] m_op   = '0;
    logic [3:0] m_ra   = '0;
    logic [3:0] m_rb   = '0;

    function automatic logic legal(input logic [4:0] op);
        return (op == 5'b01110) || (DIV_EN && op == 5'b01111);
    endfunction

    function automatic logic [37:0] expect_vec(input int step, input logic [31:0] ir,
                                               input logic [4:0] op, input logic [3:0] rb);
        logic [13:0] strobes;   // PCout MARin IncPC Zin Zlowout Zhiout PCin Read MDRin MDRout IRin Yin LOin HIin
        logic [15:0] r;
        logic [4:0]  a;
        logic        dn;
        logic        ill;
        strobes = '0;
        r       = '0;
        a       = '0;
        dn      = 1'b0;
        ill     = 1'b0;
        case (step)
            1: strobes = 14'b1111_0000_0000_00;
            2: strobes = 14'b0000_1011_1000_00;
            3: strobes = 14'b0000_0000_0110_00;
            4: if (legal(ir[31:27])) begin
                   r       = 16'h0001 << ir[26:23];
                   strobes = 14'b0000_0000_0001_00;
               end else begin
                   ill = 1'b1;
               end
            5: begin
                   r       = 16'h0001 << rb;
                   a       = op;
                   strobes = 14'b0001_0000_0000_00;
               end
            6: strobes = 14'b0000_1000_0000_10;
            7: begin
                   strobes = 14'b0000_0100_0000_01;
                   dn      = 1'b1;
               end
            default: ;
        endcase
        return {strobes, r, a, (step != 0), dn, ill};
    endfunction

    always @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            m_step <= 0;
            m_op   <= '0;
            m_ra   <= '0;
            m_rb   <= '0;
        end else begin
            case (m_step)
                0: if (start) m_step <= 1;
                2: if (mem_rdy) m_step <= 3;
                4: if (legal(IR[31:27])) begin
                       m_op   <= IR[31:27];
                       m_ra   <= IR[26:23];
                       m_rb   <= IR[22:19];
                       m_step <= 5;
                   end else begin
                       m_step <= 0;
                   end
                7: m_step <= 0;
                default: m_step <= m_step + 1;
            endcase
        end
    end

    always @(negedge clk) begin
        check("outputs", 64'(dut_vec), 64'(expect_vec(m_step, IR, m_op, m_rb)));
        check("bus_excl", 64'($countones({PCout, Zlowout, Zhiout, MDRout, Rout}) <= 1), 64'd1);
    end

    logic [37:0] snap [1:20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start pulse and records the 20 cycles after it is sampled.
    // mem_rdy is held low for `stalls` T1 cycles.
    task automatic run_seq(input logic [31:0] ir, input int stalls);
        IR      = ir;
        mem_rdy = (stalls == 0);
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            snap[n] = dut_vec;
            if (n == stalls + 2) mem_rdy = 1'b1;
        end
        tick();
    endtask

    function automatic int first_set(input int bit_idx);
        for (int n = 1; n <= 20; n++) if (snap[n][bit_idx]) return n;
        return 0;
    endfunction

    function automatic int count_set(input int bit_idx);
        int c;
        c = 0;
        for (int n = 1; n <= 20; n++) if (snap[n][bit_idx]) c++;
        return c;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0:       r[31:27] = 5'b01110;
            1:       r[31:27] = 5'b01111;
            default: ;
        endcase
        return r;
    endfunction

    int dones;

    initial begin
        #2 Clear = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rout", 64'(Rout), 64'd0);
        tick();
        Clear = 1'b1;
        repeat (2) tick();

        // MUL R1,R2
        run_seq(IR_MUL_R1_R2, 0);
        check("mul_t3_rout", 64'(snap[4][23:8]), 64'h0002);
        check("mul_t3_yin", 64'(snap[4][26]), 64'd1);
        check("mul_t4_rout", 64'(snap[5][23:8]), 64'h0004);
        check("mul_t4_aluop", 64'(snap[5][7:3]), 64'b01110);
        check("mul_t5_loin", 64'(snap[6][25]), 64'd1);
        check("mul_t6_hiin", 64'(snap[7][24]), 64'd1);
        check("mul_done_lat", 64'(first_set(1)), 64'd7);
        check("mul_done_cnt", 64'(count_set(1)), 64'd1);

        // DIV R3,R4
        run_seq(IR_DIV_R3_R4, 0);
        if (DIV_EN) begin
            check("div_t3_rout", 64'(snap[4][23:8]), 64'h0008);
            check("div_t4_rout", 64'(snap[5][23:8]), 64'h0010);
            check("div_t4_aluop", 64'(snap[5][7:3]), 64'b01111);
            check("div_done_lat", 64'(first_set(1)), 64'd7);
        end else begin
            check("div_illegal_t3", 64'(snap[4][0]), 64'd1);
            check("div_no_yin", 64'(snap[4][26]), 64'd0);
            check("div_idle_after", 64'(snap[5][2]), 64'd0);
            check("div_no_done", 64'(count_set(1)), 64'd0);
        end

        // Opcode 0
        run_seq(32'h0000_0000, 0);
        check("zero_illegal_t3", 64'(snap[4][0]), 64'd1);
        check("zero_illegal_cnt", 64'(count_set(0)), 64'd1);
        check("zero_no_done", 64'(count_set(1)), 64'd0);
        check("zero_busy_after", 64'(snap[5][2]), 64'd0);

        // Three memory wait cycles
        run_seq(IR_MUL_R1_R2, 3);
        check("stall_read_cnt", 64'(count_set(30)), 64'd4);
        check("stall_mdrin_cnt", 64'(count_set(29)), 64'd4);
        check("stall_done_lat", 64'(first_set(1)), 64'd10);

        // Clear asserted in T4
        IR      = IR_MUL_R1_R2;
        mem_rdy = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_clear_zin", 64'(Zin), 64'd1);
        #1 Clear = 1'b0;
        #1;
        check("clear_rout", 64'(Rout), 64'd0);
        check("clear_zin", 64'(Zin), 64'd0);
        check("clear_busy", 64'(busy), 64'd0);
        tick();
        Clear = 1'b1;
        repeat (2) tick();
        run_seq(IR_MUL_R1_R2, 0);
        check("post_clear_done_lat", 64'(first_set(1)), 64'd7);

        // start held high: one sequence per IDLE visit
        IR      = IR_MUL_R1_R2;
        mem_rdy = 1'b1;
        start   = 1'b1;
        tick();
        dones = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (done) dones++;
            if (n == 8) check("held_idle_gap", 64'(busy), 64'd0);
            if (n == 15) check("held_second_done", 64'(done), 64'd1);
        end
        start = 1'b0;
        check("held_done_cnt", 64'(dones), 64'd2);
        repeat (10) tick();

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            tick();
            start   = ($urandom_range(0, 3) == 0);
            mem_rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) IR = rand_ir();
            if ($urandom_range(0, 299) == 0) begin
                Clear = 1'b0;
                tick();
                Clear = 1'b1;
            end
        end
        start = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
